charge_timer: RTL and testbench

CHARGE_TIMER -- requirements
Module: charge_timer

---
 rtl/charge_timer_pkg.sv | 37 +++
 rtl/charge_timer_bin2bcd6.sv | 22 ++
 rtl/charge_timer.sv | 138 +++++++++++++
 tb/tb_charge_timer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/charge_timer_pkg.sv
// Shared charger definitions: state encoding, payment clamp and time limits.
// Used by charge_timer and by the charging controller.
package charge_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOAD,
        ST_CHARGE,
        ST_DONE
    } chg_state_t;

    localparam int PAY_CLAMP = 20;
    localparam int MAX_TIME  = 60;
    localparam int TIME_W    = 6;

    // Payment digits above 9 saturate to 9 before the unit clamp.
    function automatic logic [TIME_W-1:0] pay_to_seconds(
        input logic [3:0] tens,
        input logic [3:0] ones,
        input int         sec_per_unit
    );
        int t;
        int o;
        int p;
        int s;
        t = (tens > 4'd9) ? 9 : int'(tens);
        o = (ones > 4'd9) ? 9 : int'(ones);
        p = 10 * t + o;
        if (p > PAY_CLAMP) p = PAY_CLAMP;
        s = p * sec_per_unit;
        if (s > MAX_TIME) s = MAX_TIME;
        if (s < 0) s = 0;
        return TIME_W'(s);
    endfunction

endpackage

// File: rtl/charge_timer_bin2bcd6.sv
// Combinational 6-bit binary to two-digit BCD converter.
module bin2bcd6 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] rem;

    always_comb begin
        tens = 4'd0;
        rem  = bin;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        ones = rem[3:0];
    end

endmodule

// File: rtl/charge_timer.sv
// Charge/idle countdown timer with one-second prescaler and BCD display.
module charge_timer
    import charge_timer_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int WAIT_SECONDS = 10,
    parameter int SEC_PER_UNIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       timer_reset,
    input  logic       timing,
    input  logic       state_timing,
    input  logic [3:0] pay_tens,
    input  logic [3:0] pay_ones,
    output logic [5:0] current_time,
    output logic       end_timing,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam int WAIT_CLAMP =
        (WAIT_SECONDS > MAX_TIME) ? MAX_TIME : WAIT_SECONDS;
    localparam logic [5:0] WAIT_INIT = 6'(WAIT_CLAMP);

    chg_state_t    state_q;
    chg_state_t    state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [5:0]    ct_d;
    logic          end_d;
    logic [3:0]    tens_d;
    logic [3:0]    ones_d;
    logic          tick;
    logic [5:0]    load_val;

    assign tick     = (presc_q == PRESC_TOP);
    assign load_val = pay_to_seconds(pay_tens, pay_ones, SEC_PER_UNIT);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        ct_d    = current_time;
        end_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (timing) begin
                    state_d = ST_LOAD;
                    presc_d = '0;
                end else if (state_timing) begin
                    state_d = ST_WAIT;
                    presc_d = '0;
                    ct_d    = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (timing) begin
                    state_d = ST_LOAD;
                    presc_d = '0;
                end else if (!state_timing) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (current_time <= 6'd1) begin
                        ct_d    = 6'd0;
                        end_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ct_d = current_time - 6'd1;
                    end
                end
            end
            ST_LOAD: begin
                ct_d = load_val;
                if (load_val != 6'd0) begin
                    state_d = ST_CHARGE;
                end else begin
                    state_d = ST_DONE;
                    end_d   = 1'b1;
                end
            end
            ST_CHARGE: begin
                // Unplugging mid-charge keeps the remaining time on display.
                if (!timing) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (current_time <= 6'd1) begin
                        ct_d    = 6'd0;
                        end_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ct_d = current_time - 6'd1;
                    end
                end
            end
            ST_DONE: begin
                ct_d = 6'd0;
                if (!timing) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ct_d    = 6'd0;
            end
        endcase
        if (timer_reset) begin
            state_d = ST_IDLE;
            presc_d = '0;
            ct_d    = 6'd0;
            end_d   = 1'b0;
        end
    end

    bin2bcd6 u_bcd (
        .bin  (ct_d),
        .tens (tens_d),
        .ones (ones_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            current_time <= 6'd0;
            end_timing   <= 1'b0;
            time_tens    <= 4'd0;
            time_ones    <= 4'd0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            current_time <= ct_d;
            end_timing   <= end_d;
            time_tens    <= tens_d;
            time_ones    <= ones_d;
        end
    end

endmodule

// File: tb/tb_charge_timer.sv
// Directed bench for charge_timer with TICK_DIV=4, WAIT_SECONDS=10.
module tb_charge_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       timer_reset;
    logic       timing;
    logic       state_timing;
    logic [3:0] pay_tens;
    logic [3:0] pay_ones;
    logic [5:0] current_time;
    logic       end_timing;
    logic [3:0] time_tens;
    logic [3:0] time_ones;

    int checks = 0;
    int failures = 0;

    charge_timer #(
        .TICK_DIV     (4),
        .WAIT_SECONDS (10),
        .SEC_PER_UNIT (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .timer_reset  (timer_reset),
        .timing       (timing),
        .state_timing (state_timing),
        .pay_tens     (pay_tens),
        .pay_ones     (pay_ones),
        .current_time (current_time),
        .end_timing   (end_timing),
        .time_tens    (time_tens),
        .time_ones    (time_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pt;
        logic [3:0] po;
        int         ct;
        int         tn;
        int         on;
        int         et;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        timer_reset  = 1'b1;
        timing       = 1'b0;
        state_timing = 1'b0;
        step();
        timer_reset = 1'b0;
        step();
    endtask

    task automatic chk_out(input string name, input int exp_ct, input int exp_et);
        chk({name, ".ct"}, current_time, exp_ct);
        chk({name, ".tens"}, time_tens, exp_ct / 10);
        chk({name, ".ones"}, time_ones, exp_ct % 10);
        chk({name, ".end"}, end_timing, exp_et);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd0,  4'd7,  21, 2, 1, 0};
        vecs[1] = '{4'd9,  4'd9,  60, 6, 0, 0};
        vecs[2] = '{4'd0,  4'd12, 27, 2, 7, 0};
        vecs[3] = '{4'd1,  4'd0,  30, 3, 0, 0};
        vecs[4] = '{4'd0,  4'd0,  0,  0, 0, 1};
        vecs[5] = '{4'd2,  4'd5,  60, 6, 0, 0};
        vecs[6] = '{4'd15, 4'd15, 60, 6, 0, 0};
        vecs[7] = '{4'd0,  4'd1,  3,  0, 3, 0};
        vecs[8] = '{4'd0,  4'd6,  18, 1, 8, 0};
        vecs[9] = '{4'd1,  4'd3,  39, 3, 9, 0};

        reset        = 1'b0;
        timer_reset  = 1'b0;
        timing       = 1'b0;
        state_timing = 1'b0;
        pay_tens     = 4'd0;
        pay_ones     = 4'd0;
        repeat (3) step();
        chk_out("reset", 0, 0);
        reset = 1'b1;
        step();
        chk_out("post_reset", 0, 0);

        // Load table: one LOAD per payment pattern
        for (int i = 0; i < 10; i++) begin
            clear();
            pay_tens = vecs[i].pt;
            pay_ones = vecs[i].po;
            timing   = 1'b1;
            step();
            step();
            chk($sformatf("load%0d.ct", i), current_time, vecs[i].ct);
            chk($sformatf("load%0d.tens", i), time_tens, vecs[i].tn);
            chk($sformatf("load%0d.ones", i), time_ones, vecs[i].on);
            chk($sformatf("load%0d.end", i), end_timing, vecs[i].et);
        end

        // Full charge of 21 s, then DONE held with timing high
        clear();
        pay_tens = 4'd0;
        pay_ones = 4'd7;
        timing   = 1'b1;
        step();
        for (int k = 1; k <= 94; k++) begin
            step();
            chk_out($sformatf("charge_k%0d", k),
                    (k <= 84) ? 21 - k / 4 : 0, (k == 84) ? 1 : 0);
        end

        // Full idle countdown 10..0
        clear();
        state_timing = 1'b1;
        step();
        chk_out("wait_k0", 10, 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk_out($sformatf("wait_k%0d", k), 10 - k / 4, (k == 40) ? 1 : 0);
        end
        state_timing = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("wait_after%0d", k), 0, 0);
        end

        // Drop state_timing at 5: no pulse, value held
        clear();
        state_timing = 1'b1;
        repeat (21) step();
        chk_out("wdrop_at5", 5, 0);
        state_timing = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_out($sformatf("wdrop_k%0d", k), 5, 0);
        end

        // Zero payment: immediate DONE pulse, no repeat while held
        clear();
        pay_tens = 4'd0;
        pay_ones = 4'd0;
        timing   = 1'b1;
        step();
        chk("zero_load.end", end_timing, 0);
        step();
        chk_out("zero_done", 0, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out($sformatf("zero_hold%0d", k), 0, 0);
        end

        // timer_reset mid-charge at 13, then reload from IDLE
        clear();
        pay_tens = 4'd0;
        pay_ones = 4'd7;
        timing   = 1'b1;
        repeat (34) step();
        chk("tr_mid.ct", current_time, 13);
        timer_reset = 1'b1;
        step();
        chk_out("tr_clear", 0, 0);
        timer_reset = 1'b0;
        step();
        chk_out("tr_idle_load", 0, 0);
        step();
        chk_out("tr_reload", 21, 0);

        // Async-free reset during WAIT clears all outputs
        clear();
        state_timing = 1'b1;
        repeat (6) step();
        chk("rst_wait.ct", current_time, 9);
        reset = 1'b0;
        step();
        chk_out("rst_wait", 0, 0);
        reset        = 1'b1;
        state_timing = 1'b0;
        step();
        chk_out("rst_wait_rel", 0, 0);

        // Unplug mid-charge: value held, no pulse
        clear();
        pay_tens = 4'd1;
        pay_ones = 4'd0;
        timing   = 1'b1;
        repeat (13) step();
        chk("unplug_mid.ct", current_time, 27);
        timing = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_out($sformatf("unplug_k%0d", k), 27, 0);
        end

        // timing and state_timing rising together: LOAD wins
        clear();
        pay_tens     = 4'd0;
        pay_ones     = 4'd7;
        timing       = 1'b1;
        state_timing = 1'b1;
        step();
        chk_out("both_load", 0, 0);
        step();
        chk_out("both_value", 21, 0);
        clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
